// File: rtl/aes_round_key_store_128.sv
// Round-key store for AES-128: captures the cipher key and the ten expanded round keys, then
// serves registered forward/inverse reads. Optional per-byte parity via KEYMEM_PARITY_EN.
module aes_round_key_store_128 #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] short_key,
    input  logic [KEY_W-1:0] subkey,
    input  logic [3:0]       cnt128,
    input  logic             valid_skey,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    input  logic             rd_inv,
    output logic [KEY_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err,
    output logic             keys_ready,
    output logic             load_err,
    output logic             par_err,
    output logic [1:0]       dbg_state
);

    localparam int         DEPTH = NUM_ROUNDS + 1;
    localparam logic [3:0] LAST  = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_exp_idx;
    logic [3:0]       w_next_idx;
    logic             r_keys_ready;
    logic             r_load_err;
    logic             w_seq_err;
    logic             w_wr_en;
    logic [3:0]       w_wr_idx;
    logic [KEY_W-1:0] w_wr_data;
    logic [KEY_W-1:0] r_mem [0:DEPTH-1];

    logic [KEY_W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_rd_err;
    logic [3:0]       w_slot;
    logic             w_rd_ok;
    logic             w_rd_rej;

    // start wins over any load activity; writes are only taken in LOAD and in strict index order
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_exp_idx;
        w_seq_err    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = 4'd0;
        w_wr_data    = subkey;
        if (start) begin
            w_next_state = LOAD;
            w_next_idx   = 4'd1;
            w_wr_en      = 1'b1;
            w_wr_data    = short_key;
        end else if (r_state == LOAD && valid_skey) begin
            if (cnt128 == r_exp_idx) begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_exp_idx;
                if (r_exp_idx == LAST) begin
                    w_next_state = READY;
                end else begin
                    w_next_idx = r_exp_idx + 4'd1;
                end
            end else begin
                w_seq_err    = 1'b1;
                w_next_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_exp_idx    <= 4'd0;
            r_keys_ready <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_exp_idx    <= w_next_idx;
            r_keys_ready <= (w_next_state == READY);
            if (start) begin
                r_load_err <= 1'b0;
            end else if (w_seq_err) begin
                r_load_err <= 1'b1;
            end
        end
    end

`ifdef KEYMEM_PARITY_EN
    localparam int NB = KEY_W / 8;

    logic [NB-1:0] r_par [0:DEPTH-1];
    logic          r_par_err;

    function automatic logic [NB-1:0] byte_par(input logic [KEY_W-1:0] d);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) begin
            p[b] = ^d[b*8 +: 8];
        end
        return p;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_data;
`ifdef KEYMEM_PARITY_EN
            r_par[w_wr_idx] <= byte_par(w_wr_data);
`endif
        end
    end

    // Read handshake: rd_en sampled at an edge yields exactly one of rd_valid (rd_data updated)
    // or rd_err (rd_data held) on the next cycle; no backpressure, one request per cycle.
    assign w_slot   = rd_inv ? (LAST - rd_round) : rd_round;
    assign w_rd_ok  = rd_en && !start && (r_state == READY) && (rd_round <= LAST);
    assign w_rd_rej = rd_en && !w_rd_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_rd_err   <= w_rd_rej;
            if (w_rd_ok) begin
                r_rd_data <= r_mem[w_slot];
            end
        end
    end

`ifdef KEYMEM_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_rd_ok && (byte_par(r_mem[w_slot]) != r_par[w_slot]);
        end
    end
    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign rd_err     = r_rd_err;
    assign keys_ready = r_keys_ready;
    assign load_err   = r_load_err;
    assign dbg_state  = r_state;

endmodule
